// File: rtl/tt_sel_seq.sv
// tt_sel_seq: parametrised design-select sequencer.
// Synchronises the sel_rst_n / sel_inc / ena pads, counts inc edges into a
// {mux, block} address, validates it against the branch map on commit, and
// sequences power-up (pg_ena, then um_ena) and power-down in reverse order.
//
// Ports:
//   clk, rst        - system clock, synchronous active-high reset
//   pad_sel_rst_n   - async pad, low clears counter / forces shutdown
//   pad_sel_inc     - async pad, rising edge increments counter
//   pad_ena         - async pad, rising edge commits, falling edge releases
//   sel_mux/sel_blk - committed branch / block index
//   sel_valid       - committed address valid and powering or powered
//   um_pg_ena       - power-gate enable for the selected block
//   um_ena          - functional enable for the selected block
//   sel_err         - last commit attempt was invalid
//   cnt_ovf         - sticky counter wrap flag
//   busy            - power sequence in progress
module tt_sel_seq #(
  parameter int unsigned      G_X         = 16,
  parameter int unsigned      G_Y         = 24,
  parameter logic [G_Y-1:0]   MUX_MASK    = '0,
  parameter int unsigned      SYNC_STAGES = 2,
  parameter int unsigned      PG_DELAY    = 8,
  localparam int unsigned     AB          = (G_X > 1) ? $clog2(G_X) : 1,
  localparam int unsigned     AM          = (G_Y > 1) ? $clog2(G_Y) : 1,
  localparam int unsigned     AW          = AM + AB
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pad_sel_rst_n,
  input  logic          pad_sel_inc,
  input  logic          pad_ena,
  output logic [AM-1:0] sel_mux,
  output logic [AB-1:0] sel_blk,
  output logic          sel_valid,
  output logic          um_pg_ena,
  output logic          um_ena,
  output logic          sel_err,
  output logic          cnt_ovf,
  output logic          busy
);

  localparam int unsigned     DW       = $clog2(PG_DELAY) + 1;
  localparam logic [DW-1:0]   DLY_LOAD = DW'(PG_DELAY - 1);

  typedef enum logic [2:0] {IDLE, COUNT, PG_UP, ACTIVE, PG_DOWN} state_t;

  logic [SYNC_STAGES-1:0] rst_n_sync, inc_sync, ena_sync;
  logic                   inc_hist, ena_hist;
  logic                   rst_n_s, inc_rise, ena_rise, ena_fall;

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [AM-1:0] mux_q, mux_d;
  logic [AB-1:0] blk_q, blk_d;
  logic          err_q, err_d, ovf_q, ovf_d;
  logic          pend_q, pend_d;
  logic          clear;
  logic          dly_done;

  // sel_rst_n is only used as a level, so it needs no history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      rst_n_sync <= '0;
      inc_sync   <= '0;
      ena_sync   <= '0;
      inc_hist   <= 1'b0;
      ena_hist   <= 1'b0;
    end else begin
      rst_n_sync <= {rst_n_sync[SYNC_STAGES-2:0], pad_sel_rst_n};
      inc_sync   <= {inc_sync[SYNC_STAGES-2:0], pad_sel_inc};
      ena_sync   <= {ena_sync[SYNC_STAGES-2:0], pad_ena};
      inc_hist   <= inc_sync[SYNC_STAGES-1];
      ena_hist   <= ena_sync[SYNC_STAGES-1];
    end
  end

  assign rst_n_s  = rst_n_sync[SYNC_STAGES-1];
  assign inc_rise = inc_sync[SYNC_STAGES-1] & ~inc_hist;
  assign ena_rise = ena_sync[SYNC_STAGES-1] & ~ena_hist;
  assign ena_fall = ~ena_sync[SYNC_STAGES-1] & ena_hist;
  assign dly_done = (dly_q == '0);

  function automatic logic addr_valid(input logic [AW-1:0] a);
    logic [AM-1:0] m;
    logic [AB-1:0] b;
    m = a[AW-1:AB];
    b = a[AB-1:0];
    addr_valid = 1'b0;
    for (int unsigned i = 0; i < G_Y; i++) begin
      if (32'(m) == i && !MUX_MASK[i]) addr_valid = 1'b1;
    end
    if (32'(b) >= G_X) addr_valid = 1'b0;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dly_d   = dly_q;
    mux_d   = mux_q;
    blk_d   = blk_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    pend_d  = pend_q;
    clear   = 1'b0;
    unique case (state_q)
      IDLE: begin
        clear   = 1'b1;
        state_d = rst_n_s ? COUNT : IDLE;
      end
      COUNT: begin
        if (!rst_n_s) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (ena_rise) begin
          // A same-cycle inc edge is dropped: the commit sees the old count.
          if (addr_valid(cnt_q)) begin
            mux_d   = cnt_q[AW-1:AB];
            blk_d   = cnt_q[AB-1:0];
            err_d   = 1'b0;
            dly_d   = DLY_LOAD;
            state_d = PG_UP;
          end else begin
            err_d = 1'b1;
          end
        end else if (inc_rise) begin
          cnt_d = cnt_q + AW'(1);
          if (&cnt_q) ovf_d = 1'b1;
        end
      end
      PG_UP, ACTIVE: begin
        if (!rst_n_s || ena_fall) begin
          pend_d  = pend_q | ~rst_n_s;
          dly_d   = DLY_LOAD;
          state_d = PG_DOWN;
        end else if (state_q == PG_UP) begin
          if (dly_done) state_d = ACTIVE;
          else          dly_d   = dly_q - DW'(1);
        end
      end
      PG_DOWN: begin
        if (!rst_n_s) pend_d = 1'b1;
        if (dly_done) begin
          if (pend_q || !rst_n_s) begin
            clear   = 1'b1;
            state_d = IDLE;
          end else begin
            state_d = COUNT;
          end
        end else begin
          dly_d = dly_q - DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (clear) begin
      cnt_d  = '0;
      mux_d  = '0;
      blk_d  = '0;
      err_d  = 1'b0;
      ovf_d  = 1'b0;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dly_q   <= '0;
      mux_q   <= '0;
      blk_q   <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dly_q   <= dly_d;
      mux_q   <= mux_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      pend_q  <= pend_d;
    end
  end

  // Enables decode straight from the registered state, so um_ena can only
  // be high while pg_ena and sel_valid are high.
  assign um_pg_ena = (state_q == PG_UP) || (state_q == ACTIVE) || (state_q == PG_DOWN);
  assign sel_valid = um_pg_ena;
  assign um_ena    = (state_q == ACTIVE);
  assign busy      = (state_q == PG_UP) || (state_q == PG_DOWN);
  assign sel_mux   = mux_q;
  assign sel_blk   = blk_q;
  assign sel_err   = err_q;
  assign cnt_ovf   = ovf_q;

endmodule

// File: doc/tt_sel_seq.md
Name: tt_sel_seq

Overview:
- Parametrised design-select sequencer; successor to the fixed pad-driven select logic in the controller.
- Converts the asynchronous pad controls sel_rst_n / sel_inc / ena into a validated {mux, block} address.
- Validation skips masked or non-existent branches.
- Power-up/down is sequenced: pg_ena first, um_ena after a programmable delay, and the reverse order on power-down.
- Sits between the control pads and the spine address/enable drivers in tt_top.

Parameters:
- G_X, 16, user blocks per mux branch.
- G_Y, 24, number of mux branches.
- MUX_MASK, {G_Y{1'b0}}, bit i = 1: branch i absent; any address selecting it is invalid.
- SYNC_STAGES, 2, synchroniser depth per pad input (>=2).
- PG_DELAY, 8, clocks between pg_ena and um_ena transitions (>=1).
- Derived: AB = clog2(G_X), AM = clog2(G_Y), AW = AM+AB.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- pad_sel_rst_n  input  1  async pad; low clears the counter and forces shutdown.
- pad_sel_inc  input  1  async pad; each rising edge increments the counter.
- pad_ena  input  1  async pad; rising edge commits the address, falling edge releases it.
- sel_mux  output  AM  committed branch index.
- sel_blk  output  AB  committed block index.
- sel_valid  output  1  committed address is valid and the design is powering or powered.
- um_pg_ena  output  1  power-gate enable for the selected block.
- um_ena  output  1  functional enable for the selected block.
- sel_err  output  1  last commit attempt was invalid; cleared on next commit or sel_rst_n low.
- cnt_ovf  output  1  sticky; counter wrapped; cleared only by rst or sel_rst_n low.
- busy  output  1  high in PG_UP or PG_DOWN.

Behaviour:
- Reset (rst=1 at clk edge) overrides all other logic:
  - Synchroniser flops and edge history are set to 0; counter = 0; state = IDLE.
  - All outputs are 0 from the next cycle. This holds mid-sequence too, with no orderly power-down.
- Synchronisers: each pad passes through SYNC_STAGES flops, then one history flop.
  - An edge is detected when sync output differs from history.
  - Total latency L = SYNC_STAGES+1 clocks from the first clk edge sampling the new pad level to the registered output change.
- Counter: AW bits, low AB bits = block, high AM bits = mux.
  - Increments only in COUNT, on an inc rising edge.
  - From all-ones it wraps to 0 and sets cnt_ovf.
  - Inc edges in any other state are ignored.
- Validity check: address is valid iff blk < G_X, mux < G_Y and MUX_MASK[mux] = 0.
- State machine:
  - IDLE: counter held at 0; outputs 0. sel_rst_n_s = 1 -> COUNT.
  - COUNT, ena rising edge:
    - Valid address: sel_mux/sel_blk latch the counter value, sel_valid = 1, um_pg_ena = 1, sel_err = 0; go to PG_UP and start the delay counter.
    - Invalid address: sel_err = 1, stay in COUNT, no power change.
  - PG_UP: after PG_DELAY clocks, um_ena = 1 -> ACTIVE.
  - ACTIVE: outputs stable; inc ignored.
    - ena falling edge: um_ena = 0 -> PG_DOWN.
  - PG_DOWN: after PG_DELAY clocks, um_pg_ena = 0 and sel_valid = 0 -> COUNT. sel_mux/sel_blk keep their last value.
- Priority and simultaneous events:
  - sel_rst_n_s = 0 in COUNT: -> IDLE; counter, sel_err and cnt_ovf are cleared.
  - sel_rst_n_s = 0 in PG_UP: um_ena stays 0 -> PG_DOWN.
  - sel_rst_n_s = 0 in ACTIVE: um_ena = 0 next cycle -> PG_DOWN.
  - From PG_DOWN, a pending reset request exits to IDLE, not COUNT.
  - ena falling in PG_UP: abort; um_ena is never asserted -> PG_DOWN with a full PG_DELAY.
  - ena rising in PG_DOWN: ignored. A new edge is required in COUNT.
  - inc and ena rising in the same COUNT cycle: the commit uses the pre-increment value, and the increment is discarded.
- Invariant: um_ena = 1 implies um_pg_ena = 1 and sel_valid = 1, every cycle.

Test Plan:
Configuration for all scenarios: G_X=16, G_Y=4, MUX_MASK=4'b0100, SYNC_STAGES=2, PG_DELAY=4 (L=3).
1. rst high 2 cycles, pads toggling -> all outputs 0; counter 0; state IDLE.
2. sel_rst_n high, 5 inc pulses (4 clk high/low), ena rise at T -> at T+3: sel_mux=0, sel_blk=5, sel_valid=1, um_pg_ena=1, busy=1. At T+7: um_ena=1, busy=0.
3. 37 inc pulses (mux=2, masked), ena rise -> sel_err=1 at T+3; um_pg_ena stays 0; a second commit at count 38 still errors.
4. 64 inc pulses, then 1 more -> cnt_ovf=1, counter=1; commit gives sel_mux=0, sel_blk=1.
5. From ACTIVE, ena fall at T -> um_ena=0 at T+3; um_pg_ena=0 and sel_valid=0 at T+7; state COUNT.
6. From ACTIVE, sel_rst_n fall, then rst asserted in PG_DOWN -> no cycle with um_ena=1 and um_pg_ena=0; after rst all outputs 0.
